lv_efuse_load_ctrl: RTL and testbench
=====================================

Name: lv_efuse_load_ctrl

Overview:
- Serves the efuse load request from the LV control FSM (`o_efuse_load_req` / `i_efuse_load_done`).
- Sequentially reads EFUSE_WORD_NUM words from the efuse macro with programmable setup and read-strobe timing.
- Writes each word into the register-file shadow registers and checks the stored checksum.
- Returns a one-cycle done pulse plus a registered valid flag. The valid flag feeds the register file's efuse-valid bit.

Parameters:
- EFUSE_WORD_NUM, 8, number of efuse words read per load; the last word is the checksum (>=2).
- EFUSE_DATA_W, 8, width of one efuse word.
- EFUSE_ADDR_W, 3, word address width (2^EFUSE_ADDR_W >= EFUSE_WORD_NUM).
- RD_SETUP_CYC, 2, cycles with csb low and address stable before the read strobe (>=1).
- RD_PULSE_CYC, 4, width in cycles of the read strobe `o_efuse_rden` (>=1).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_efuse_load_req  in  1  level request from the control FSM; held until done.
- o_efuse_load_done  out  1  one-cycle pulse when a load completes.
- o_efuse_busy  out  1  high while a load is in progress.
- o_efuse_vld  out  1  checksum-pass flag from the last completed load.
- o_efuse_csb  out  1  efuse macro chip select, active low.
- o_efuse_rden  out  1  efuse macro read strobe.
- o_efuse_addr  out  EFUSE_ADDR_W  efuse macro word address.
- i_efuse_rdata  in  EFUSE_DATA_W  efuse macro read data; valid while rden is high.
- o_efuse_wr_en  out  1  one-cycle write strobe to the shadow register.
- o_efuse_wr_addr  out  EFUSE_ADDR_W  shadow register word index.
- o_efuse_wr_data  out  EFUSE_DATA_W  shadow register write data.

Behaviour:
- Interface (already decided): one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - csb=1, rden=0, addr=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - done=0, busy=0, vld=0.
  - Internal req_d=0; state=IDLE.
- Start condition: rising edge of req (req=1 & req_d=0) while in IDLE.
  - A rise seen at the edge ending cycle T puts the block in SETUP during T+1.
  - Because req_d resets to 0, a req that is high when reset releases starts a load.
- FSM states: IDLE, SETUP, READ, WRITE, DONE.
- IDLE:
  - csb=1, rden=0, busy=0.
  - On start: word index=0, vld cleared to 0, go to SETUP.
- SETUP:
  - csb=0, addr=word index, busy=1.
  - Lasts RD_SETUP_CYC cycles, then go to READ.
- READ:
  - rden=1 for RD_PULSE_CYC cycles.
  - rdata is captured at the edge ending the last READ cycle; then go to WRITE.
- WRITE (one cycle):
  - rden=0, wr_en=1, wr_addr=index, wr_data=captured word.
  - Update xor_acc for index < N-1; update or_acc for all words.
  - If index == N-1, go to DONE; otherwise index+1 and go to SETUP. csb stays low between words.
- DONE (one cycle):
  - done=1, csb=1.
  - vld = (xor_acc of words 0..N-2 == word N-1) & (or_acc != 0), so an unprogrammed all-zero fuse is invalid.
  - Go to IDLE.
- Per-word latency is RD_SETUP_CYC + RD_PULSE_CYC + 1 cycles. With defaults the DONE cycle is T+57.
- Abort: if req falls in SETUP/READ/WRITE:
  - Next cycle state=IDLE, csb=1, rden=0, busy=0.
  - No done pulse; vld stays 0; any partial shadow writes already issued remain.
- A req rise while busy is ignored.
- req held high after DONE does not retrigger; a new load needs req to go low and then high.
- req falling in the DONE cycle itself: the load still completes.
- Reset mid-load: all outputs take reset values at the next edge, and the macro is released (csb=1).
- xor_acc and or_acc are EFUSE_DATA_W wide and cleared on start; the word index saturates at N-1.

Test Plan:
- Defaults, words 0x11,0x22,0x44,0x08,0x00,0x00,0x00,0x7F, req rises at T → eight wr_en pulses with addr 0..7 and matching data, rden high 4 cycles per word, done pulse at T+57, vld=1, csb high again at T+58.
- Same data but last word 0x7E → done at T+57, vld=0, all eight writes still issued.
- All words 0x00 → done pulses, vld=0.
- req drops during the READ of word 3 → next cycle csb=1, rden=0, busy=0, no done, vld=0; req raised again → full reload from addr 0 and done after 57 cycles.
- i_rst asserted during word 5 with req held high → outputs at reset values next edge; after reset releases, a new load starts from addr 0 and completes with a done pulse.
- req held high for 100 cycles after done → exactly one load; req toggled low→high → a second load, and vld is cleared to 0 at its start.

Source files
------------

// File: rtl/lv_efuse_load_ctrl.sv
// rtl/lv_efuse_load_ctrl.sv - efuse load sequencer: macro read timing, shadow writes, checksum check
//
// Purpose:
//   Reads EFUSE_WORD_NUM words from the efuse macro when the LV control FSM
//   raises its load request. Setup and read-strobe widths are programmable.
//   Each word is written to the register-file shadow registers. The last word
//   is a checksum: the XOR of all preceding words. The valid flag requires the
//   checksum to match and at least one bit in the array to be set.
//
// Ports:
//   i_clk             system clock
//   i_rst             synchronous active-high reset
//   i_efuse_load_req  level load request, held until done
//   o_efuse_load_done one-cycle pulse when a load completes
//   o_efuse_busy      high while a load is in progress
//   o_efuse_vld       checksum-pass flag from the last completed load
//   o_efuse_csb       macro chip select, active low
//   o_efuse_rden      macro read strobe
//   o_efuse_addr      macro word address
//   i_efuse_rdata     macro read data, valid while rden is high
//   o_efuse_wr_en     one-cycle shadow register write strobe
//   o_efuse_wr_addr   shadow register word index
//   o_efuse_wr_data   shadow register write data

module lv_efuse_load_ctrl #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_DATA_W   = 8,
    parameter int EFUSE_ADDR_W   = 3,
    parameter int RD_SETUP_CYC   = 2,
    parameter int RD_PULSE_CYC   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_efuse_load_req,
    output logic                    o_efuse_load_done,
    output logic                    o_efuse_busy,
    output logic                    o_efuse_vld,
    output logic                    o_efuse_csb,
    output logic                    o_efuse_rden,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
    input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
    output logic                    o_efuse_wr_en,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_wr_addr,
    output logic [EFUSE_DATA_W-1:0] o_efuse_wr_data
);

    // One shared phase counter serves both SETUP and READ, so it is sized
    // for the longer of the two.
    localparam int CNT_MAX = (RD_SETUP_CYC > RD_PULSE_CYC) ? RD_SETUP_CYC : RD_PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]        SETUP_LAST = CNT_W'(RD_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]        PULSE_LAST = CNT_W'(RD_PULSE_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] IDX_LAST   = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_req_d;
    logic [CNT_W-1:0]        r_cnt;
    logic [EFUSE_ADDR_W-1:0] r_idx;
    logic [EFUSE_DATA_W-1:0] r_xor_acc;
    logic [EFUSE_DATA_W-1:0] r_or_acc;

    logic                    r_done;
    logic                    r_busy;
    logic                    r_vld;
    logic                    r_csb;
    logic                    r_rden;
    logic [EFUSE_ADDR_W-1:0] r_addr;
    logic                    r_wr_en;
    logic [EFUSE_ADDR_W-1:0] r_wr_addr;
    logic [EFUSE_DATA_W-1:0] r_wr_data;

    logic w_start;
    logic w_abort;
    logic w_sum_ok;

    // Only a rising edge starts a load, so a request left high after DONE
    // cannot retrigger. req_d resets to 0, so a request already high when
    // reset releases does start a load.
    assign w_start = (r_state == S_IDLE) && i_efuse_load_req && !r_req_d;

    // Dropping the request mid-load abandons the load. Once DONE is reached,
    // the load completes regardless of the request level.
    assign w_abort = !i_efuse_load_req &&
                     ((r_state == S_SETUP) || (r_state == S_READ) || (r_state == S_WRITE));

    // Evaluated in the last WRITE cycle. At that point r_wr_data holds the
    // checksum word, and both accumulators already include every word that
    // contributes to them.
    assign w_sum_ok = (r_xor_acc == r_wr_data) && (r_or_acc != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_req_d   <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_xor_acc <= '0;
            r_or_acc  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_vld     <= 1'b0;
            r_csb     <= 1'b1;
            r_rden    <= 1'b0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_req_d <= i_efuse_load_req;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            if (w_abort) begin
                r_state <= S_IDLE;
                r_csb   <= 1'b1;
                r_rden  <= 1'b0;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_idx     <= '0;
                            r_addr    <= '0;
                            r_vld     <= 1'b0;
                            r_xor_acc <= '0;
                            r_or_acc  <= '0;
                            r_cnt     <= '0;
                            r_csb     <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= S_SETUP;
                        end
                    end

                    S_SETUP: begin
                        if (r_cnt == SETUP_LAST) begin
                            r_cnt   <= '0;
                            r_rden  <= 1'b1;
                            r_state <= S_READ;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    S_READ: begin
                        if (r_cnt == PULSE_LAST) begin
                            // The macro data is captured on the edge that
                            // ends the strobe, while rden is still high.
                            r_cnt     <= '0;
                            r_rden    <= 1'b0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_idx;
                            r_wr_data <= i_efuse_rdata;
                            if (r_idx != IDX_LAST) begin
                                r_xor_acc <= r_xor_acc ^ i_efuse_rdata;
                            end
                            r_or_acc  <= r_or_acc | i_efuse_rdata;
                            r_state   <= S_WRITE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    S_WRITE: begin
                        if (r_idx == IDX_LAST) begin
                            r_done  <= 1'b1;
                            r_csb   <= 1'b1;
                            r_vld   <= w_sum_ok;
                            r_state <= S_DONE;
                        end else begin
                            // csb stays low across words; only the address moves.
                            r_idx   <= r_idx + EFUSE_ADDR_W'(1);
                            r_addr  <= r_idx + EFUSE_ADDR_W'(1);
                            r_state <= S_SETUP;
                        end
                    end

                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_csb   <= 1'b1;
                        r_rden  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_efuse_load_done = r_done;
    assign o_efuse_busy      = r_busy;
    assign o_efuse_vld       = r_vld;
    assign o_efuse_csb       = r_csb;
    assign o_efuse_rden      = r_rden;
    assign o_efuse_addr      = r_addr;
    assign o_efuse_wr_en     = r_wr_en;
    assign o_efuse_wr_addr   = r_wr_addr;
    assign o_efuse_wr_data   = r_wr_data;

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// tb/tb_lv_efuse_load_ctrl.sv - scoreboard bench for lv_efuse_load_ctrl
module tb_lv_efuse_load_ctrl;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int SU  = 2;
    localparam int PU  = 4;
    localparam int PER = SU + PU + 1;
    localparam int DONE_LAT = PER * N + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          o_done, o_busy, o_vld, o_csb, o_rden, o_wr_en;
    logic [AW-1:0] o_addr, o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic [DW-1:0] rdata;
    logic [DW-1:0] mem [N];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
    typedef struct { logic v; int c; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    lv_efuse_load_ctrl #(
        .EFUSE_WORD_NUM(N), .EFUSE_DATA_W(DW), .EFUSE_ADDR_W(AW),
        .RD_SETUP_CYC(SU), .RD_PULSE_CYC(PU)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_efuse_load_req(req),
        .o_efuse_load_done(o_done),
        .o_efuse_busy(o_busy),
        .o_efuse_vld(o_vld),
        .o_efuse_csb(o_csb),
        .o_efuse_rden(o_rden),
        .o_efuse_addr(o_addr),
        .i_efuse_rdata(rdata),
        .o_efuse_wr_en(o_wr_en),
        .o_efuse_wr_addr(o_wr_addr),
        .o_efuse_wr_data(o_wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: data only meaningful while rden is high; junk otherwise.
    always_comb begin
        rdata = o_rden ? mem[o_addr] : (8'h5A ^ cyc[7:0]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req_v, cyc);
    endtask

    // Checksum rule: XOR of words 0..N-2 equals word N-1, and the array is not blank.
    function automatic logic model_vld();
        logic [DW-1:0] x, o;
        x = '0; o = '0;
        for (int k = 0; k < N - 1; k++) x ^= mem[k];
        for (int k = 0; k < N; k++) o |= mem[k];
        return (x == mem[N-1]) && (o != '0);
    endfunction

    // Expected writes whose WRITE cycle falls at or before cycle 'last'.
    task automatic push_writes(input int t, input int last);
        for (int k = 0; k < N; k++) begin
            if (t + PER * k + PER <= last) wq.push_back('{a: AW'(k), d: mem[k], c: t + PER * k + PER});
        end
    endtask

    task automatic push_full(input int t);
        push_writes(t, t + DONE_LAT);
        dq.push_back('{v: model_vld(), c: t + DONE_LAT});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to_cycle(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [19:0] outvec();
        return {o_csb, o_rden, o_addr, o_wr_en, o_wr_addr, o_wr_data, o_done, o_busy, o_vld};
    endfunction

    // Full load: req low on the previous edge, raised now, dropped after T+58 checks.
    task automatic run_full(input string nm);
        int t;
        tick();
        req = 1'b1;
        t = cyc;
        push_full(t);
        go_to_cycle(t + DONE_LAT + 1);
        @(negedge clk);
        chk({nm, "_csb_after_done"}, 32'(o_csb), 32'd1);
        chk({nm, "_vld"}, 32'(o_vld), 32'(model_vld()));
        chk({nm, "_busy_after"}, 32'(o_busy), 32'd0);
        tick();
        req = 1'b0;
    endtask

    task automatic load_vec(input logic [63:0] v);
        logic [63:0] tmp;
        tmp = v;
        for (int k = 0; k < N; k++) mem[k] = tmp[8*(N-1-k) +: 8];
    endtask

    // Monitor / scoreboard
    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin : mon
        wr_t w;
        dn_t d;
        if (o_rden) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (o_wr_en) begin
            if (wq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write (cycle %0d)", o_wr_addr, o_wr_data, cyc);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(o_wr_addr), 32'(w.a));
                chk("wr_data", 32'(o_wr_data), 32'(w.d));
                chk("wr_cycle", 32'(cyc), 32'(w.c));
                chk("rden_width", 32'(last_run), 32'(PU));
                chk("csb_in_write", 32'(o_csb), 32'd0);
            end
        end
        if (o_done) begin
            if (dq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done actual=done at cycle %0d required=no done", cyc);
            end else begin
                d = dq.pop_front();
                chk("done_cycle", 32'(cyc), 32'(d.c));
                chk("done_vld", 32'(o_vld), 32'(d.v));
            end
        end
    end

    initial begin
        int t, t2;
        for (int k = 0; k < N; k++) mem[k] = '0;
        rst = 1'b1;
        req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_state", 32'(outvec()), 32'h80000);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        load_vec(64'h1122_4408_0000_007F);
        run_full("vec_good");
        load_vec(64'h1122_4408_0000_007E);
        run_full("vec_bad_sum");
        load_vec(64'h0);
        run_full("vec_zero");

        // Abort during READ of word 3 (READ occupies T+24..T+27).
        load_vec(64'h1122_4408_0000_007F);
        tick();
        req = 1'b1;
        t = cyc;
        push_writes(t, t + 25);
        go_to_cycle(t + 25);
        req = 1'b0;
        go_to_cycle(t + 26);
        @(negedge clk);
        chk("abort_csb_rden_busy", 32'({o_csb, o_rden, o_busy}), 32'b100);
        chk("abort_vld", 32'(o_vld), 32'd0);
        repeat (5) tick();
        chk("abort_no_done_vld", 32'(o_vld), 32'd0);
        run_full("reload_after_abort");

        // Reset during word 5 with req held high, then restart on release.
        for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
        tick();
        req = 1'b1;
        t = cyc;
        push_writes(t, t + 38);
        go_to_cycle(t + 38);
        rst = 1'b1;
        go_to_cycle(t + 39);
        @(negedge clk);
        chk("midload_reset_state", 32'(outvec()), 32'h80000);
        repeat (2) tick();
        rst = 1'b0;
        t2 = cyc;
        push_full(t2);
        go_to_cycle(t2 + DONE_LAT + 1);
        @(negedge clk);
        chk("post_reset_csb", 32'(o_csb), 32'd1);
        tick();
        req = 1'b0;

        // Hold req high 100 cycles past done: one load only; then re-toggle.
        load_vec(64'h1122_4408_0000_007F);
        tick();
        req = 1'b1;
        t = cyc;
        push_full(t);
        go_to_cycle(t + DONE_LAT + 1);
        @(negedge clk);
        chk("hold_vld", 32'(o_vld), 32'd1);
        go_to_cycle(t + DONE_LAT + 101);
        chk("hold_no_retrigger_busy", 32'(o_busy), 32'd0);
        req = 1'b0;
        tick();
        req = 1'b1;
        t2 = cyc;
        push_full(t2);
        go_to_cycle(t2 + 1);
        @(negedge clk);
        chk("vld_cleared_on_start", 32'(o_vld), 32'd0);
        go_to_cycle(t2 + DONE_LAT + 1);
        tick();
        req = 1'b0;

        // Randomized loads against the checksum model.
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] x;
            x = '0;
            for (int k = 0; k < N; k++) mem[k] = 8'($urandom);
            for (int k = 0; k < N - 1; k++) x ^= mem[k];
            if ($urandom_range(0, 1) == 1) mem[N-1] = x;
            if ($urandom_range(0, 7) == 0) for (int k = 0; k < N; k++) mem[k] = '0;
            run_full("rand");
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (10) tick();
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("dones_outstanding", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
